// File: rtl/mat_mul_seq_ctrl_if.sv
// rtl/mat_mul_seq_ctrl_if.sv - word streams and multiplier bus of the matrix-multiply sequencer
// slave is the sequencer side; master is the host/multiplier side.
interface mat_mul_seq_ctrl_if #(
  parameter int MAX_SIZE = 13,
  parameter int DATA_BW  = 16
);
  localparam int SQU_MAX_SIZE = MAX_SIZE * MAX_SIZE;

  logic                              in_valid;
  logic [DATA_BW-1:0]                in_data;
  logic                              in_ready;
  logic                              out_valid;
  logic [2*DATA_BW-1:0]              out_data;
  logic                              out_ready;
  logic                              mm_start;
  logic [SQU_MAX_SIZE*DATA_BW-1:0]   mm_data_inA;
  logic [SQU_MAX_SIZE*DATA_BW-1:0]   mm_data_inB;
  logic [SQU_MAX_SIZE*2*DATA_BW-1:0] mm_data_out;
  logic                              mm_finish;
  logic                              busy;
  logic                              done;

  modport slave (
    input  in_valid, in_data, out_ready, mm_data_out, mm_finish,
    output in_ready, out_valid, out_data, mm_start, mm_data_inA, mm_data_inB, busy, done
  );

  modport master (
    output in_valid, in_data, out_ready, mm_data_out, mm_finish,
    input  in_ready, out_valid, out_data, mm_start, mm_data_inA, mm_data_inB, busy, done
  );
endinterface

// File: rtl/mat_mul_seq_ctrl.sv
// rtl/mat_mul_seq_ctrl.sv - loads A/B from a word stream, runs the multiplier, streams the product
// Elements are row-major; idx walks 0..SQU_MAX_SIZE-1 in every phase.
module mat_mul_seq_ctrl #(
  parameter int MAX_SIZE     = 13,
  parameter int SQU_MAX_SIZE = MAX_SIZE * MAX_SIZE,
  parameter int DATA_BW      = 16
) (
  input  logic               clk,
  input  logic               rst,
  mat_mul_seq_ctrl_if.slave  bus
);
  localparam logic [1:0] LOAD_A  = 2'd0;
  localparam logic [1:0] LOAD_B  = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] STREAM  = 2'd3;
  localparam logic [7:0] LAST_IDX = 8'(SQU_MAX_SIZE - 1);

  logic [1:0]                        state;
  logic [7:0]                        idx;
  logic [SQU_MAX_SIZE*DATA_BW-1:0]   a_buf;
  logic [SQU_MAX_SIZE*DATA_BW-1:0]   b_buf;
  logic [SQU_MAX_SIZE*2*DATA_BW-1:0] result_buf;
  logic                              finish_d;
  logic                              mm_start_r;
  logic                              done_r;
  logic                              in_xfer;
  logic                              out_xfer;
  logic                              finish_rise;

  assign bus.in_ready    = (state == LOAD_A) || (state == LOAD_B);
  assign bus.out_valid   = (state == STREAM);
  assign bus.busy        = (state == COMPUTE) || (state == STREAM);
  assign bus.done        = done_r;
  assign bus.mm_start    = mm_start_r;
  assign bus.mm_data_inA = a_buf;
  assign bus.mm_data_inB = b_buf;
  assign bus.out_data    = result_buf[32'(idx)*(2*DATA_BW) +: 2*DATA_BW];

  assign in_xfer     = bus.in_valid & bus.in_ready;
  assign out_xfer    = bus.out_valid & bus.out_ready;
  // A finish already high when COMPUTE begins is stale; only a fresh rise completes.
  assign finish_rise = bus.mm_finish & ~finish_d;

  always_ff @(posedge clk) begin
    finish_d <= bus.mm_finish;
    done_r   <= 1'b0;
    if (rst) begin
      state      <= LOAD_A;
      idx        <= 8'd0;
      mm_start_r <= 1'b0;
      a_buf      <= '0;
      b_buf      <= '0;
      result_buf <= '0;
      finish_d   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_xfer) begin
            a_buf[32'(idx)*DATA_BW +: DATA_BW] <= bus.in_data;
            if (idx == LAST_IDX) begin
              idx   <= 8'd0;
              state <= LOAD_B;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        LOAD_B: begin
          if (in_xfer) begin
            b_buf[32'(idx)*DATA_BW +: DATA_BW] <= bus.in_data;
            if (idx == LAST_IDX) begin
              idx        <= 8'd0;
              mm_start_r <= 1'b1;
              state      <= COMPUTE;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        COMPUTE: begin
          if (finish_rise) begin
            result_buf <= bus.mm_data_out;
            mm_start_r <= 1'b0;
            idx        <= 8'd0;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (out_xfer) begin
            if (idx == LAST_IDX) begin
              idx    <= 8'd0;
              done_r <= 1'b1;
              state  <= LOAD_A;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_mul_seq_ctrl.sv
// tb/tb_mat_mul_seq_ctrl.sv - directed bench for mat_mul_seq_ctrl with a behavioural multiplier
// The multiplier drives junk on mm_data_out while idle so an early capture shows up as bad results.
module tb_mat_mul_seq_ctrl;
  localparam int N   = 13;
  localparam int SQ  = N * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mat_mul_seq_ctrl_if ifc ();
  mat_mul_seq_ctrl dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  int total = 0;
  int bad = 0;
  int accepted = 0;
  int a_v [SQ];
  int b_v [SQ];
  int exp_v [SQ];
  logic [31:0] got [SQ];
  logic [31:0] got1 [SQ];
  bit stale_mode = 1'b0;
  int mcnt = 0;

  function automatic logic [SQ*32-1:0] mm_model(input logic [SQ*16-1:0] a, input logic [SQ*16-1:0] b);
    logic [SQ*32-1:0] r = '0;
    logic [31:0] s;
    for (int row = 0; row < N; row++)
      for (int col = 0; col < N; col++) begin
        s = 32'd0;
        for (int k = 0; k < N; k++)
          s = s + 32'(a[(row*N+k)*16 +: 16]) * 32'(b[(k*N+col)*16 +: 16]);
        r[(row*N+col)*32 +: 32] = s;
      end
    return r;
  endfunction

  // Behavioural multiplier: finish rises 10 cycles after start, or the stale pattern.
  always @(posedge clk) begin
    if (!ifc.mm_start) begin
      mcnt            <= 0;
      ifc.mm_finish   <= stale_mode;
      ifc.mm_data_out <= '1;
    end else begin
      mcnt <= mcnt + 1;
      if (stale_mode) ifc.mm_finish <= (mcnt < 4) || (mcnt >= 19);
      else            ifc.mm_finish <= (mcnt >= 9);
      if (mcnt == 2) ifc.mm_data_out <= mm_model(ifc.mm_data_inA, ifc.mm_data_inB);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [SQ*16-1:0] pack_a();
    logic [SQ*16-1:0] r = '0;
    for (int e = 0; e < SQ; e++) r[e*16 +: 16] = 16'(a_v[e]);
    return r;
  endfunction

  function automatic logic [SQ*16-1:0] pack_b();
    logic [SQ*16-1:0] r = '0;
    for (int e = 0; e < SQ; e++) r[e*16 +: 16] = 16'(b_v[e]);
    return r;
  endfunction

  task automatic compute_exp();
    for (int row = 0; row < N; row++)
      for (int col = 0; col < N; col++) begin
        exp_v[row*N+col] = 0;
        for (int k = 0; k < N; k++) exp_v[row*N+col] += a_v[row*N+k] * b_v[k*N+col];
      end
  endtask

  task automatic send_word(input logic [15:0] d, input bit toggle);
    int g = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    while (!ifc.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("in_ready_timeout", 32'(g), 32'd0);
    @(negedge clk);
    accepted++;
    ifc.in_valid = 1'b0;
    if (toggle) @(negedge clk);
  endtask

  task automatic load_all(input bit toggle, input string tag);
    for (int e = 0; e < SQ; e++) send_word(16'(a_v[e]), toggle);
    for (int e = 0; e < SQ - 1; e++) send_word(16'(b_v[e]), toggle);
    check({tag, "_start_before_last"}, 32'(ifc.mm_start), 32'd0);
    send_word(16'(b_v[SQ-1]), 1'b0);
    check({tag, "_start_rise"}, 32'(ifc.mm_start), 32'd1);
  endtask

  task automatic wait_stream(input int exp_lat, input string tag);
    int lat = 0;
    int hold_bad = 0;
    int rdy_bad = 0;
    ifc.out_ready = 1'b0;
    while (!ifc.out_valid && lat < 300) begin
      if (!ifc.mm_start) hold_bad++;
      if (ifc.in_ready) rdy_bad++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_start_held"}, 32'(hold_bad), 32'd0);
    check({tag, "_compute_no_ready"}, 32'(rdy_bad), 32'd0);
    check({tag, "_start_dropped"}, 32'(ifc.mm_start), 32'd0);
    check({tag, "_busy"}, 32'(ifc.busy), 32'd1);
  endtask

  task automatic recv_stream(input bit stall, input int max_n, input string tag);
    int n = 0, cyc = 0, dn = 0, stall_bad = 0, stalls = 0, rdy_bad = 0;
    logic [31:0] held = '0;
    bit hv = 1'b0;
    bit rdy;
    while (n < max_n && cyc < 3000) begin
      rdy = stall ? (cyc % 4 == 3) : 1'b1;
      ifc.out_ready = rdy;
      if (ifc.done) dn++;
      if (ifc.in_ready) rdy_bad++;
      if (hv && ifc.out_data !== held) stall_bad++;
      if (ifc.out_valid) begin
        if (rdy) begin
          got[n] = ifc.out_data;
          n++;
          hv = 1'b0;
        end else begin
          held = ifc.out_data;
          hv = 1'b1;
          stalls++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_beats"}, 32'(n), 32'(max_n));
    check({tag, "_stream_no_ready"}, 32'(rdy_bad), 32'd0);
    check({tag, "_stall_hold"}, 32'(stall_bad), 32'd0);
    if (stall) check({tag, "_stalls_seen"}, 32'(stalls > 0), 32'd1);
    if (max_n == SQ) begin
      check({tag, "_done_now"}, 32'(ifc.done), 32'd1);
      check({tag, "_out_valid_off"}, 32'(ifc.out_valid), 32'd0);
      check({tag, "_in_ready_back"}, 32'(ifc.in_ready), 32'd1);
      check({tag, "_busy_off"}, 32'(ifc.busy), 32'd0);
      if (ifc.done) dn++;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (ifc.done) dn++;
      end
      check({tag, "_done_once"}, 32'(dn), 32'd1);
    end
  endtask

  task automatic check_results(input string tag);
    int errs = 0;
    for (int e = 0; e < SQ; e++) if (got[e] !== 32'(exp_v[e])) errs++;
    check({tag, "_result_errors"}, 32'(errs), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(ifc.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
    check({tag, "_mm_start"}, 32'(ifc.mm_start), 32'd0);
    check({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    check({tag, "_a_zero"}, 32'(ifc.mm_data_inA == '0), 32'd1);
    check({tag, "_b_zero"}, 32'(ifc.mm_data_inB == '0), 32'd1);
    check({tag, "_res_zero"}, 32'(dut.result_buf == '0), 32'd1);
    check({tag, "_idx"}, 32'(dut.idx), 32'd0);
  endtask

  initial begin
    int errs;
    rst = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    check("reset_done", 32'(ifc.done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 32'(ifc.in_ready), 32'd1);

    // 1: A[e]=e, B[e]=169+e back-to-back
    for (int e = 0; e < SQ; e++) begin a_v[e] = e; b_v[e] = SQ + e; end
    compute_exp();
    accepted = 0;
    load_all(1'b0, "s1");
    check("s1_accepted", 32'(accepted), 32'd338);
    wait_stream(11, "s1");
    recv_stream(1'b0, SQ, "s1");
    check("s1_out0", got[0], 32'd21632);
    check("s1_out168", got[SQ-1], 32'd547820);
    check_results("s1");
    for (int e = 0; e < SQ; e++) got1[e] = got[e];

    // 2: gapped input, 1-in-4 output ready
    load_all(1'b1, "s2");
    wait_stream(11, "s2");
    recv_stream(1'b1, SQ, "s2");
    errs = 0;
    for (int e = 0; e < SQ; e++) if (got[e] !== got1[e]) errs++;
    check("s2_same_as_s1", 32'(errs), 32'd0);

    // 3: identity times B[e]=e
    for (int e = 0; e < SQ; e++) begin
      a_v[e] = (e / N == e % N) ? 1 : 0;
      b_v[e] = e;
      exp_v[e] = e;
    end
    load_all(1'b0, "s3");
    wait_stream(11, "s3");
    recv_stream(1'b0, SQ, "s3");
    check("s3_out100", got[100], 32'd100);
    check_results("s3");

    // 4: finish already high on entry, drops, rises again
    stale_mode = 1'b1;
    repeat (2) @(negedge clk);
    load_all(1'b0, "s4");
    wait_stream(21, "s4");
    recv_stream(1'b0, SQ, "s4");
    check_results("s4");
    stale_mode = 1'b0;
    repeat (2) @(negedge clk);

    // 6: in_valid held high through COMPUTE and STREAM
    for (int e = 0; e < SQ; e++) begin a_v[e] = e; b_v[e] = SQ + e; end
    compute_exp();
    load_all(1'b0, "s6");
    ifc.in_valid = 1'b1;
    ifc.in_data  = 16'hBEEF;
    wait_stream(11, "s6");
    recv_stream(1'b0, SQ, "s6");
    check_results("s6");
    check("s6_a_unchanged", 32'(ifc.mm_data_inA === pack_a()), 32'd1);
    check("s6_b_unchanged", 32'(ifc.mm_data_inB === pack_b()), 32'd1);

    // 5a: reset after 50 B beats
    for (int e = 0; e < SQ; e++) send_word(16'(a_v[e]), 1'b0);
    for (int e = 0; e < 50; e++) send_word(16'(b_v[e]), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("s5a");
    rst = 1'b0;
    @(negedge clk);

    // 5b: reset at stream index 80
    load_all(1'b0, "s5b");
    wait_stream(11, "s5b");
    recv_stream(1'b0, 80, "s5b");
    check("s5b_mid_stream", 32'(ifc.out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("s5b");
    rst = 1'b0;
    ifc.out_ready = 1'b0;
    @(negedge clk);

    // fresh full load after the resets
    load_all(1'b0, "s5c");
    wait_stream(11, "s5c");
    recv_stream(1'b0, SQ, "s5c");
    check("s5c_out168", got[SQ-1], 32'd547820);
    check_results("s5c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mat_mul_seq_ctrl.md
Name: mat_mul_seq_ctrl

Overview:
Sequencer wrapped around Mat_Mul_16bits, the 13x13, 16-bit matrix multiplier. It collects matrix A and matrix B from a 16-bit valid/ready word stream and packs them into the multiplier's flat input buses. It then runs the start/finish handshake, captures the 32-bit product matrix, and streams the 169 results out over a valid/ready port. This lets host or DMA logic drive the multiplier without 2704-bit wide buses.

Parameters:
MAX_SIZE, 13, matrix dimension (square).
SQU_MAX_SIZE, 169, MAX_SIZE*MAX_SIZE, elements per matrix.
DATA_BW, 16, input element width; result width is 2*DATA_BW.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_data  in  DATA_BW  input element
in_ready  out  1  block can accept a word
out_valid  out  1  result word valid
out_data  out  2*DATA_BW  result element
out_ready  in  1  downstream accepts the result word
mm_start  out  1  start level to the multiplier
mm_data_inA  out  SQU_MAX_SIZE*DATA_BW  packed matrix A
mm_data_inB  out  SQU_MAX_SIZE*DATA_BW  packed matrix B
mm_data_out  in  SQU_MAX_SIZE*2*DATA_BW  packed product from the multiplier
mm_finish  in  1  multiplier finish flag
busy  out  1  high in COMPUTE and STREAM
done  out  1  one-cycle pulse after the last result transfer

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (including mid-operation):
  - state=LOAD_A; idx counter=0.
  - mm_start=0; A, B and result buffers cleared to 0; finish_d=0.
  - out_valid=0, busy=0, done=0; in_ready=1 from the first cycle after reset.
  - Any partial load or stream is discarded.
- Element order is row-major:
  - Element e = row*MAX_SIZE + col.
  - Inputs occupy bits [e*DATA_BW +: DATA_BW].
  - Results occupy [e*2*DATA_BW +: 2*DATA_BW].
- State LOAD_A:
  - in_ready=1.
  - On in_valid & in_ready: A[idx] <= in_data, idx++.
  - When idx=168 and a transfer occurs: idx <= 0, go to LOAD_B.
- State LOAD_B:
  - Same as LOAD_A but writes B.
  - On the 169th word: go to COMPUTE with mm_start <= 1, registered, so mm_start rises the cycle after the last B beat.
- State COMPUTE:
  - in_ready=0; mm_start held at 1; busy=1.
  - finish_d registers mm_finish every cycle.
  - Completion is a rising edge only: mm_finish=1 & finish_d=0.
  - A finish that is already high on COMPUTE entry is stale; the block waits for it to drop and rise again.
  - On the rising edge: result <= mm_data_out (same edge), mm_start <= 0, idx <= 0, go to STREAM.
  - No timeout: COMPUTE waits indefinitely until the next rise of mm_finish.
- State STREAM:
  - out_valid=1; out_data=result[idx], combinational from the registered buffer and idx.
  - out_data is stable while out_valid & !out_ready.
  - On out_valid & out_ready: idx++.
  - Transfer at idx=168: out_valid=0 next cycle, done=1 for exactly one cycle, idx=0, go to LOAD_A.
- Stability: mm_data_inA/B are driven directly from the buffers and stay stable from the end of LOAD_B through STREAM. They change only in the next LOAD_A/LOAD_B.
- in_ready and out_valid are never high together. in_valid outside LOAD_A/LOAD_B is ignored and the data is not consumed.
- Arithmetic: no arithmetic on data; products pass through unmodified at 32 bits. idx is 8 bits and never exceeds 168.
- Minimum total latency, with continuous valid/ready: 338 load cycles + 1 + multiplier time + 1 capture + 169 stream cycles.

Test Plan:
1. A[e]=e, B[e]=169+e streamed back-to-back with the real multiplier -> 338 accepted beats; mm_start rises one cycle after the last beat; stream gives out_data[0]=21632 and out_data[168]=547820; done pulses once; in_ready=1 again.
2. in_valid toggled 1/0 every cycle during load, and out_ready low 3 of every 4 cycles during stream -> identical results to scenario 1; out_data held constant during each stall; exactly 169 output beats.
3. A=identity, B[e]=e -> out_data[e]=e for e=0..168.
4. Multiplier model with mm_finish held high on COMPUTE entry, dropping after 5 cycles and rising after 20 -> capture happens only on the later rising edge; mm_start stays 1 until then.
5. rst pulsed at B beat 50, and separately at stream index 80 -> next cycle: state LOAD_A, mm_start=0, out_valid=0, all buffers 0. A fresh full load then produces correct results.
6. in_valid=1 held during COMPUTE and STREAM -> no words consumed (in_ready=0); A/B buses unchanged.
